// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
// The counter width is derived from WIDTH so the top and any future cells agree on it.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The counter must hold WIDTH-1 and must never be zero bits wide.
    function automatic int cntWidth(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle for the serial adder.
// The master issues operands and a start pulse; the slave returns the status and the result.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder_full_adder.sv
// Combinational one-bit full-adder cell.
// It is the bitwise dual of the subtractor cell: the carry replaces the borrow.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic co_o
);
    assign s_o  = a_i ^ b_i ^ cin_i;
    assign co_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands LSB-first through one full-adder cell.
// It presents {cout,sum} together with a one-cycle done pulse.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);
    localparam int CNT_W = cntWidth(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] aSr_q;
    logic [WIDTH-1:0] bSr_q;
    logic [WIDTH-1:0] sumSr_q;
    logic [WIDTH-1:0] sumSr_d;
    logic             carry_q;
    logic [CNT_W-1:0] count_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             faSum;
    logic             faCarry;

    full_adder u_fa (
        .a_i   (aSr_q[0]),
        .b_i   (bSr_q[0]),
        .cin_i (carry_q),
        .s_o   (faSum),
        .co_o  (faCarry)
    );

    // Each new sum bit enters at the MSB; after WIDTH steps bit 0 sits at the LSB.
    always_comb begin
        sumSr_d = (sumSr_q >> 1) | (WIDTH'(faSum) << (WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            aSr_q   <= '0;
            bSr_q   <= '0;
            sumSr_q <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        aSr_q   <= bus.a;
                        bSr_q   <= bus.b;
                        carry_q <= bus.cin;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    aSr_q   <= aSr_q >> 1;
                    bSr_q   <= bSr_q >> 1;
                    sumSr_q <= sumSr_d;
                    carry_q <= faCarry;
                    count_q <= count_q + CNT_W'(1);
                    // The result is published on the same edge that enters DONE.
                    if (count_q == LAST) begin
                        sum_q   <= sumSr_d;
                        cout_q  <= faCarry;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8 and WIDTH=1.
// Inputs are driven and outputs sampled on the falling edge.
module tb_serial_adder;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   cyc;

    serial_adder_if #(.WIDTH(8)) bus8();
    serial_adder_if #(.WIDTH(1)) bus1();

    serial_adder #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Hard stop in case a DUT wedges somewhere outside the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required finish before it");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks += 4;
        if (bus8.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b want=0", bus8.busy); end
        if (bus8.done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b want=0", bus8.done); end
        if (bus8.sum !== 8'h00) begin failures++; $display("[TB] FAIL reset_sum got=%h want=00", bus8.sum); end
        if (bus8.cout !== 1'b0) begin failures++; $display("[TB] FAIL reset_cout got=%b want=0", bus8.cout); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // 0x5A + 0x3C: checks busy/done on every cycle of the operation.
    task automatic test_basic();
        bus8.a = 8'h5A; bus8.b = 8'h3C; bus8.cin = 1'b0; bus8.start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            bus8.start = 1'b0;
            checks += 2;
            if (bus8.busy !== (k <= 8)) begin
                failures++;
                $display("[TB] FAIL basic_busy k=%0d got=%b want=%b", k, bus8.busy, (k <= 8));
            end
            if (bus8.done !== (k == 8)) begin
                failures++;
                $display("[TB] FAIL basic_done k=%0d got=%b want=%b", k, bus8.done, (k == 8));
            end
            if (k == 8) begin
                checks += 2;
                if (bus8.sum !== 8'h96) begin failures++; $display("[TB] FAIL basic_sum got=%h want=96", bus8.sum); end
                if (bus8.cout !== 1'b0) begin failures++; $display("[TB] FAIL basic_cout got=%b want=0", bus8.cout); end
            end
        end
    endtask

    task automatic test_vectors();
        logic [7:0] va   [3] = '{8'hFF, 8'hFF, 8'h00};
        logic [7:0] vb   [3] = '{8'h01, 8'h00, 8'h00};
        logic       vc   [3] = '{1'b0, 1'b1, 1'b0};
        logic [7:0] eSum [3] = '{8'h00, 8'h00, 8'h00};
        logic       eCo  [3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            int lat;
            bus8.a = va[i]; bus8.b = vb[i]; bus8.cin = vc[i]; bus8.start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus8.start = 1'b0;
            lat = 0;
            while (bus8.done !== 1'b1 && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            checks += 3;
            if (lat != 8) begin failures++; $display("[TB] FAIL vec%0d_latency got=%0d want=8", i, lat); end
            if (bus8.sum !== eSum[i]) begin failures++; $display("[TB] FAIL vec%0d_sum got=%h want=%h", i, bus8.sum, eSum[i]); end
            if (bus8.cout !== eCo[i]) begin failures++; $display("[TB] FAIL vec%0d_cout got=%b want=%b", i, bus8.cout, eCo[i]); end
            @(negedge clk);
        end
    endtask

    // A second start during RUN is neither honoured nor queued.
    task automatic test_ignore_start();
        int doneCount;
        int doneAt;
        bus8.a = 8'h5A; bus8.b = 8'h3C; bus8.cin = 1'b0; bus8.start = 1'b1;
        @(posedge clk);
        doneCount = 0;
        doneAt = -1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (k == 2) begin
                bus8.start = 1'b1; bus8.a = 8'h11; bus8.b = 8'h22;
            end else begin
                bus8.start = 1'b0;
            end
            if (bus8.done === 1'b1) begin
                doneCount++;
                doneAt = k;
                checks++;
                if (bus8.sum !== 8'h96) begin failures++; $display("[TB] FAIL ignore_sum got=%h want=96", bus8.sum); end
            end
        end
        checks += 3;
        if (doneCount != 1) begin failures++; $display("[TB] FAIL ignore_done_count got=%0d want=1", doneCount); end
        if (doneAt != 8) begin failures++; $display("[TB] FAIL ignore_done_cycle got=%0d want=8", doneAt); end
        if (bus8.sum !== 8'h96) begin failures++; $display("[TB] FAIL ignore_sum_held got=%h want=96", bus8.sum); end
    endtask

    task automatic test_reset_midrun();
        int sawDone;
        int lat;
        bus8.a = 8'h01; bus8.b = 8'h02; bus8.cin = 1'b0; bus8.start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus8.start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks += 4;
        if (bus8.busy !== 1'b0) begin failures++; $display("[TB] FAIL abort_busy got=%b want=0", bus8.busy); end
        if (bus8.done !== 1'b0) begin failures++; $display("[TB] FAIL abort_done got=%b want=0", bus8.done); end
        if (bus8.sum !== 8'h00) begin failures++; $display("[TB] FAIL abort_sum got=%h want=00", bus8.sum); end
        if (bus8.cout !== 1'b0) begin failures++; $display("[TB] FAIL abort_cout got=%b want=0", bus8.cout); end
        sawDone = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus8.done === 1'b1) sawDone = 1;
        end
        checks++;
        if (sawDone != 0) begin failures++; $display("[TB] FAIL abort_no_done got=%0d want=0", sawDone); end
        bus8.a = 8'h12; bus8.b = 8'h34; bus8.cin = 1'b1; bus8.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus8.start = 1'b0;
        lat = 0;
        while (bus8.done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks += 3;
        if (lat != 8) begin failures++; $display("[TB] FAIL after_abort_latency got=%0d want=8", lat); end
        if (bus8.sum !== 8'h47) begin failures++; $display("[TB] FAIL after_abort_sum got=%h want=47", bus8.sum); end
        if (bus8.cout !== 1'b0) begin failures++; $display("[TB] FAIL after_abort_cout got=%b want=0", bus8.cout); end
        @(negedge clk);
    endtask

    // start held high; operands are scrambled during RUN and only valid in the accepting IDLE cycle.
    task automatic test_back_to_back();
        logic [7:0] va   [3] = '{8'h5A, 8'h80, 8'h0F};
        logic [7:0] vb   [3] = '{8'h3C, 8'h80, 8'hF0};
        logic       vc   [3] = '{1'b0, 1'b1, 1'b0};
        logic [7:0] eSum [3] = '{8'h96, 8'h01, 8'hFF};
        logic       eCo  [3] = '{1'b0, 1'b1, 1'b0};
        int prevCyc;
        int wait_n;
        prevCyc = 0;
        bus8.a = va[0]; bus8.b = vb[0]; bus8.cin = vc[0]; bus8.start = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus8.a = 8'hC3; bus8.b = 8'hA5; bus8.cin = ~vc[i];
            wait_n = 0;
            while (bus8.done !== 1'b1 && wait_n < 20) begin
                @(negedge clk);
                wait_n++;
            end
            checks += 2;
            if (bus8.sum !== eSum[i]) begin failures++; $display("[TB] FAIL b2b%0d_sum got=%h want=%h", i, bus8.sum, eSum[i]); end
            if (bus8.cout !== eCo[i]) begin failures++; $display("[TB] FAIL b2b%0d_cout got=%b want=%b", i, bus8.cout, eCo[i]); end
            if (i > 0) begin
                checks++;
                if (cyc - prevCyc != 10) begin
                    failures++;
                    $display("[TB] FAIL b2b%0d_spacing got=%0d want=10", i, cyc - prevCyc);
                end
            end
            prevCyc = cyc;
            @(negedge clk);
            if (i < 2) begin
                bus8.a = va[i+1]; bus8.b = vb[i+1]; bus8.cin = vc[i+1];
            end else begin
                bus8.start = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_width1();
        for (int v = 0; v < 8; v++) begin
            logic [2:0] bits;
            logic [1:0] expect_v;
            bits = 3'(v);
            expect_v = 2'(bits[2]) + 2'(bits[1]) + 2'(bits[0]);
            bus1.a = bits[2]; bus1.b = bits[1]; bus1.cin = bits[0]; bus1.start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus1.start = 1'b0;
            checks++;
            if (bus1.done !== 1'b0) begin failures++; $display("[TB] FAIL w1_early_done v=%0d got=%b want=0", v, bus1.done); end
            @(negedge clk);
            checks += 2;
            if (bus1.done !== 1'b1) begin failures++; $display("[TB] FAIL w1_done v=%0d got=%b want=1", v, bus1.done); end
            if ({bus1.cout, bus1.sum} !== expect_v) begin
                failures++;
                $display("[TB] FAIL w1_result v=%0d got=%b want=%b", v, {bus1.cout, bus1.sum}, expect_v);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
        bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_vectors();
        test_ignore_start();
        test_reset_midrun();
        test_back_to_back();
        test_width1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial adder: the addition counterpart to the team's subtractor cell. It accepts two WIDTH-bit operands and a carry-in on a start pulse. It then adds them LSB-first, one bit per clock, through a single one-bit full-adder cell and a carry flop, and presents the sum and carry-out with a one-cycle done pulse. It is used where area matters more than latency, alongside the arithmetic cells in the datapath.

## Interface
- WIDTH, 8, operand/sum width in bits; legal range 1..32.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  operand A; captured on accepted start.
- b  in  WIDTH  operand B; captured on accepted start.
- cin  in  1  carry-in; captured on accepted start.
- busy  out  1  high in RUN and DONE states.
- done  out  1  single-cycle pulse; sum/cout valid in that cycle.
- sum  out  WIDTH  result A+B+cin mod 2^WIDTH; held until next accepted start.
- cout  out  1  carry out of bit WIDTH-1; held with sum.

## Operation
- Reset (rst=1 at an edge, any state, including mid-RUN): state=IDLE; busy=0, done=0, sum=0, cout=0; operand shift registers, carry flop and bit counter cleared. Reset has priority over start.
- FSM states: IDLE, RUN, DONE.
- IDLE: if start=1, capture a, b into shift registers, carry flop←cin, counter←0, go to RUN. Otherwise hold, with outputs unchanged.
- RUN: each cycle the full-adder cell takes a_sr[0], b_sr[0] and carry. Its sum bit shifts into sum_sr at the MSB (right shift). Its carry-out loads the carry flop. a_sr and b_sr shift right. The counter increments. When counter = WIDTH-1 in this cycle, go to DONE.
- DONE: done=1 for exactly one cycle; sum=sum_sr, cout=carry flop. Next state is IDLE.
- start while busy=1 is ignored and not queued. Operand changes after capture have no effect.
- sum/cout registers update only on entry to DONE. They remain stable through IDLE until the next result.
- Arithmetic: {cout,sum} = a + b + cin, computed exactly at width WIDTH+1. No overflow flag.
- WIDTH=1: RUN lasts one cycle. Same protocol otherwise.

## Timing
- start accepted at edge T. RUN occupies edges T+1..T+WIDTH. done=1 in the cycle after edge T+WIDTH. Fixed latency is WIDTH+1 cycles from the accepting edge to done.
- Throughput: one operation per WIDTH+2 cycles. start held high continuously is re-accepted in the first IDLE cycle after done.
- busy rises the cycle after the accepting edge. It falls together with done.
- All outputs are registered. There is no combinational path from inputs to outputs.
- rst asserted during RUN aborts the operation. No done is produced, and sum/cout read 0 afterward.

## Structure
- Package serial_adder_pkg: state enum type (IDLE, RUN, DONE; 2-bit encoding); counter width constant CNT_W = max(1, $clog2(WIDTH)) provided as a function of WIDTH.
- Sub-module full_adder: combinational one-bit cell, inputs a, b, cin; outputs s = a^b^cin and co = a&b | cin&(a^b). It is the bitwise dual of the existing subtractor cell and is instantiated once.
- Top holds the FSM, the counter, the a/b/sum shift registers, the carry flop and the output registers.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, cin=0, start at T -> done=1 in exactly cycle T+9; sum=0x96, cout=0; busy high T+1..T+9.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1. Then a=0x00, b=0x00, cin=0 -> sum=0x00, cout=0.
- start pulsed again at T+3 with a=0x11, b=0x22 -> ignored; result still 0x96 at T+9 with a single done pulse.
- rst asserted at T+4 of an operation -> next cycle busy=0, done stays 0, sum=0, cout=0. A new start then completes normally.
- start held high continuously -> done pulses are spaced exactly 10 cycles apart. Each result matches the operands present in the accepting IDLE cycle.
- WIDTH=1, exhaustive over all 8 (a, b, cin) combinations -> {cout,sum} = a+b+cin; done 2 cycles after each accepting edge.
